cache_wb_assoc: RTL and testbench
=================================

// Module: cache_wb_assoc
// PURPOSE
//  Parametrised write-back, write-allocate, set-associative (1- or 2-way) cache between the CPU word port and the 128-bit memory port.
//  Line size, set count and way count are parameters. Replacement is per-set LRU.
//  Adds a flush command that writes every dirty line back to memory.
//  Drop-in for the CPU data/instruction cache slot; uses register arrays, no SRAM macros.
// PARAMETERS
//  SETS            8    number of sets, power of 2 (>=2)
//  WAYS            2    associativity; legal values 1 or 2
//  LINE_BEATS      4    memory beats per line, power of 2; line = LINE_BEATS*MEM_DATA_BITS/CPU_WIDTH words
//  CPU_WIDTH       32   CPU word width
//  WORD_ADDR_BITS  30   CPU word-address width
//  MEM_DATA_BITS   128  memory beat width
// PORTS
//  clk                 in   1    clock
//  reset               in   1    asynchronous, active-low reset
//  cpu_req_val         in   1    CPU request valid
//  cpu_req_rdy         out  1    cache accepts request this cycle
//  cpu_req_addr        in   WORD_ADDR_BITS  word address
//  cpu_req_data        in   CPU_WIDTH       store data
//  cpu_req_write       in   4    byte write enables; 0 = load
//  cpu_resp_val        out  1    load data valid (1-cycle pulse)
//  cpu_resp_data       out  CPU_WIDTH       load data
//  flush_req           in   1    start flush (level, sampled in IDLE)
//  flush_done          out  1    1-cycle pulse when flush completes
//  mem_req_val         out  1    memory command valid
//  mem_req_rdy         in   1    memory command accepted
//  mem_req_addr        out  WORD_ADDR_BITS-log2(MEM_DATA_BITS/CPU_WIDTH)  beat address (line-aligned)
//  mem_req_rw          out  1    0 read line, 1 write line
//  mem_req_data_valid  out  1    write beat valid
//  mem_req_data_ready  in   1    write beat accepted
//  mem_req_data_bits   out  MEM_DATA_BITS   write beat data
//  mem_req_data_mask   out  MEM_DATA_BITS/8 always all ones
//  mem_resp_val        in   1    read beat valid
//  mem_resp_data       in   MEM_DATA_BITS   read beat data
// BEHAVIOUR
//  Address split: {tag, index[log2 SETS], word offset[log2 line words]}. Beat k of a line is at line beat address + k.
//  Reset (async, reset=0): all outputs 0, state IDLE, valid/dirty/LRU arrays cleared. Tag/data arrays are not cleared.
//  Reset mid-transaction aborts it at once; mem_req_val/data_valid drop and dirty data is lost.
//  Handshake: a request is taken when cpu_req_val&cpu_req_rdy; addr/data/write are captured only then.
//  States: IDLE, COMPARE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, FLUSH_SCAN.
//  IDLE: cpu_req_rdy=1 unless flush_req=1. flush_req has priority (->FLUSH_SCAN). An accepted request goes to COMPARE.
//  COMPARE, hit: a load drives cpu_resp_val=1 with the word this cycle (1-cycle hit latency).
//   A store merges bytes by cpu_req_write and sets dirty. LRU points to the other way.
//   cpu_req_rdy=1 on a hit, so back-to-back hits sustain 1/cycle. No response is given for stores.
//  COMPARE, miss: cpu_req_rdy=0. Victim = first invalid way (way0 first), else the LRU way.
//   Victim valid&dirty -> WB_REQ, else FILL_REQ.
//  WB_REQ: mem_req_val=1, rw=1, addr=victim line. Held until mem_req_rdy, then WB_DATA.
//  WB_DATA: send beats 0..LINE_BEATS-1 with data_valid; a beat advances on data_ready. After the last beat -> FILL_REQ.
//  FILL_REQ: mem_req_val=1, rw=0, addr=requested line; on mem_req_rdy -> FILL_DATA.
//  FILL_DATA: beats are written in order on each mem_resp_val. The last beat sets valid=1, dirty=0, tag, LRU, then -> COMPARE (replay; guaranteed hit).
//  mem_resp_val outside FILL_DATA is ignored. No outstanding memory op is issued while another is open.
//  FLUSH_SCAN: walks sets 0..SETS-1, way 0..WAYS-1. Each valid&dirty line goes through WB_REQ/WB_DATA, then dirty=0, valid kept, and the walk returns to FLUSH_SCAN.
//   After the last entry: flush_done=1 for one cycle, then IDLE. cpu_req_rdy=0 throughout.
//  WAYS=1: LRU unused; victim is always way 0.
// TESTING
//  Defaults. Cold load addr 30'h10: FILL_REQ beat addr 28'h4 rw=0, 4 beats D0..D3 -> cpu_resp_data=D0[31:0], cpu_resp_val 1 cycle.
//  Then load 30'h11 -> hit, resp D0[63:32] the cycle after accept; no mem_req_val.
//  Store 30'h11 data 32'hAABBCCDD write 4'b0011, then load 30'h11 -> D0[63:48],16'hCCDD.
//  Loads 30'h10 and 30'h90 fill set 1 ways 0/1. Touch 30'h10, then load 30'h110 -> evicts the 30'h90 line; no writeback (clean).
//  Dirty line 30'h10 evicted by 30'h110 and 30'h90 (after a touch of 30'h90): write line 28'h4 with 4 beats before the fill of 28'h44. Stall data_ready 3 cycles -> beats held stable.
//  Two dirty lines plus flush_req: exactly 2 writebacks, flush_done pulses once, and later loads to both hit without mem traffic.
//  Assert reset during WB_DATA beat 2: outputs 0 immediately. After release, load 30'h10 misses.

Source files
------------

// File: rtl/cache_wb_assoc.sv
// Write-back, write-allocate, 1- or 2-way set-associative cache with per-set LRU
// replacement and a flush command that writes every dirty line back to memory.
// Storage is plain register arrays. LINE_BEATS is expected to be at least 2.
module cache_wb_assoc #(
    parameter int SETS           = 8,
    parameter int WAYS           = 2,
    parameter int LINE_BEATS     = 4,
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30,
    parameter int MEM_DATA_BITS  = 128
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cpu_req_val,
    output logic                                  cpu_req_rdy,
    input  logic [WORD_ADDR_BITS-1:0]             cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]                  cpu_req_data,
    input  logic [3:0]                            cpu_req_write,
    output logic                                  cpu_resp_val,
    output logic [CPU_WIDTH-1:0]                  cpu_resp_data,
    input  logic                                  flush_req,
    output logic                                  flush_done,
    output logic                                  mem_req_val,
    input  logic                                  mem_req_rdy,
    output logic [WORD_ADDR_BITS-$clog2(MEM_DATA_BITS/CPU_WIDTH)-1:0] mem_req_addr,
    output logic                                  mem_req_rw,
    output logic                                  mem_req_data_valid,
    input  logic                                  mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]              mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0]            mem_req_data_mask,
    input  logic                                  mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0]              mem_resp_data
);
    localparam int WPB    = MEM_DATA_BITS / CPU_WIDTH;
    localparam int WPB_W  = $clog2(WPB);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = BEAT_W + WPB_W;
    localparam int TAG_W  = WORD_ADDR_BITS - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, FLUSH_SCAN
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [CPU_WIDTH-1:0]      req_data_q, req_data_d;
    logic [3:0]                req_write_q, req_write_d;
    logic                      way_q, way_d;
    logic [IDX_W-1:0]          wb_set_q, wb_set_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      flushing_q, flushing_d;
    logic [IDX_W-1:0]          scan_set_q, scan_set_d;
    logic                      scan_way_q, scan_way_d;

    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    logic [MEM_DATA_BITS-1:0]  data_q [WAYS][SETS][LINE_BEATS];
    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [WAYS-1:0][SETS-1:0] dirty_q;
    logic [SETS-1:0]           lru_q;

    logic [TAG_W-1:0]          req_tag;
    logic [IDX_W-1:0]          req_idx;
    logic [BEAT_W-1:0]         req_beat;
    logic [WPB_W-1:0]          req_word;
    logic                      hit, hit_way, victim_way, victim_dirty;
    logic                      scan_dirty, scan_last;
    logic [MEM_DATA_BITS-1:0]  hit_beat, store_beat;
    logic [CPU_WIDTH-1:0]      hit_word, store_word;
    logic                      fill_we, fill_done, store_we, lru_touch, wb_clean;

    assign req_tag  = req_addr_q[WORD_ADDR_BITS-1 -: TAG_W];
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_beat = req_addr_q[WPB_W +: BEAT_W];
    assign req_word = req_addr_q[0 +: WPB_W];
    assign scan_dirty = valid_q[scan_way_q][scan_set_q] & dirty_q[scan_way_q][scan_set_q];
    assign scan_last  = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == 1'(WAYS - 1));
    assign mem_req_data_mask = '1;

    // Tag lookup for the captured request, plus victim choice (invalid way first, else LRU)
    always_comb begin
        hit = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit = 1'b1;
                hit_way = 1'(w);
            end
        end
        victim_way = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) victim_way = 1'(w);
        end
        victim_dirty = valid_q[victim_way][req_idx] & dirty_q[victim_way][req_idx];
    end

    // Hit word selection and byte-merge of store data into the hit beat
    always_comb begin
        hit_beat = data_q[hit_way][req_idx][req_beat];
        hit_word = hit_beat[req_word*CPU_WIDTH +: CPU_WIDTH];
        store_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (req_write_q[b]) store_word[b*8 +: 8] = req_data_q[b*8 +: 8];
        end
        store_beat = hit_beat;
        store_beat[req_word*CPU_WIDTH +: CPU_WIDTH] = store_word;
    end

    // Next-state logic and datapath register updates for every state
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_write_d = req_write_q;
        way_d       = way_q;
        wb_set_d    = wb_set_q;
        beat_d      = beat_q;
        flushing_d  = flushing_q;
        scan_set_d  = scan_set_q;
        scan_way_d  = scan_way_q;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        store_we    = 1'b0;
        lru_touch   = 1'b0;
        wb_clean    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d    = FLUSH_SCAN;
                    scan_set_d = '0;
                    scan_way_d = 1'b0;
                end else if (cpu_req_val) begin
                    state_d     = COMPARE;
                    req_addr_d  = cpu_req_addr;
                    req_data_d  = cpu_req_data;
                    req_write_d = cpu_req_write;
                end
            end
            COMPARE: begin
                if (hit) begin
                    store_we  = |req_write_q;
                    lru_touch = 1'b1;
                    if (cpu_req_val) begin
                        req_addr_d  = cpu_req_addr;
                        req_data_d  = cpu_req_data;
                        req_write_d = cpu_req_write;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    way_d      = victim_way;
                    wb_set_d   = req_idx;
                    flushing_d = 1'b0;
                    state_d    = victim_dirty ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                if (mem_req_rdy) begin
                    beat_d  = '0;
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                if (mem_req_data_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        if (flushing_q) begin
                            wb_clean = 1'b1;
                            state_d  = FLUSH_SCAN;
                        end else begin
                            state_d = FILL_REQ;
                        end
                    end
                end
            end
            FILL_REQ: begin
                if (mem_req_rdy) begin
                    beat_d  = '0;
                    state_d = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (mem_resp_val) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        fill_done = 1'b1;
                        state_d   = COMPARE;
                    end
                end
            end
            FLUSH_SCAN: begin
                if (scan_dirty) begin
                    way_d      = scan_way_q;
                    wb_set_d   = scan_set_q;
                    flushing_d = 1'b1;
                    state_d    = WB_REQ;
                end else if (scan_last) begin
                    state_d = IDLE;
                end else if (scan_way_q == 1'(WAYS - 1)) begin
                    scan_way_d = 1'b0;
                    scan_set_d = scan_set_q + 1'b1;
                end else begin
                    scan_way_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore-style outputs; ready is forced low while reset is held
    always_comb begin
        cpu_req_rdy        = 1'b0;
        cpu_resp_val       = 1'b0;
        cpu_resp_data      = '0;
        flush_done         = 1'b0;
        mem_req_val        = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        case (state_q)
            IDLE: cpu_req_rdy = reset & ~flush_req;
            COMPARE: begin
                if (hit) begin
                    cpu_req_rdy = 1'b1;
                    if (req_write_q == 4'b0000) begin
                        cpu_resp_val  = 1'b1;
                        cpu_resp_data = hit_word;
                    end
                end
            end
            WB_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_rw   = 1'b1;
                mem_req_addr = {tag_q[way_q][wb_set_q], wb_set_q, {BEAT_W{1'b0}}};
            end
            WB_DATA: begin
                mem_req_data_valid = 1'b1;
                mem_req_data_bits  = data_q[way_q][wb_set_q][beat_q];
            end
            FILL_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_addr = {req_tag, req_idx, {BEAT_W{1'b0}}};
            end
            FLUSH_SCAN: flush_done = ~scan_dirty & scan_last;
            default: ;
        endcase
    end

    // State and request/walk registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= '0;
            way_q       <= 1'b0;
            wb_set_q    <= '0;
            beat_q      <= '0;
            flushing_q  <= 1'b0;
            scan_set_q  <= '0;
            scan_way_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_write_q <= req_write_d;
            way_q       <= way_d;
            wb_set_q    <= wb_set_d;
            beat_q      <= beat_d;
            flushing_q  <= flushing_d;
            scan_set_q  <= scan_set_d;
            scan_way_q  <= scan_way_d;
        end
    end

    // Valid, dirty and LRU bookkeeping, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_done) begin
                valid_q[way_q][req_idx] <= 1'b1;
                dirty_q[way_q][req_idx] <= 1'b0;
                lru_q[req_idx]          <= ~way_q;
            end
            if (store_we) dirty_q[hit_way][req_idx] <= 1'b1;
            if (lru_touch) lru_q[req_idx] <= ~hit_way;
            if (wb_clean) dirty_q[way_q][wb_set_q] <= 1'b0;
        end
    end

    // Tag and data arrays are not reset; valid bits guard their contents
    always_ff @(posedge clk) begin
        if (fill_we) data_q[way_q][req_idx][beat_q] <= mem_resp_data;
        if (fill_done) tag_q[way_q][req_idx] <= req_tag;
        if (store_we) data_q[hit_way][req_idx][req_beat] <= store_beat;
    end
endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed bench for cache_wb_assoc: the bench plays CPU and memory, driving
// and sampling on the falling clock edge.
module tb_cache_wb_assoc;
    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_val;
    logic         cpu_req_rdy;
    logic [29:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic [3:0]   cpu_req_write;
    logic         cpu_resp_val;
    logic [31:0]  cpu_resp_data;
    logic         flush_req;
    logic         flush_done;
    logic         mem_req_val;
    logic         mem_req_rdy;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_val;
    logic [127:0] mem_resp_data;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] exp_line [4];

    cache_wb_assoc dut (
        .clk(clk), .reset(reset),
        .cpu_req_val(cpu_req_val), .cpu_req_rdy(cpu_req_rdy),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_req_write(cpu_req_write), .cpu_resp_val(cpu_resp_val),
        .cpu_resp_data(cpu_resp_data), .flush_req(flush_req),
        .flush_done(flush_done), .mem_req_val(mem_req_val),
        .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
        .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Backing-memory contents: word j of beat address ba is D000_0000 | ba<<8 | j
    function automatic logic [31:0] mem_word(input logic [27:0] ba, input int j);
        return 32'hD000_0000 | (32'(ba) << 8) | 32'(j);
    endfunction

    function automatic logic [127:0] mem_beat(input logic [27:0] ba);
        return {mem_word(ba, 3), mem_word(ba, 2), mem_word(ba, 1), mem_word(ba, 0)};
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cpu_req_val = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
        flush_req = 1'b0; mem_req_rdy = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_val = 1'b0; mem_resp_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Offer one CPU request and return at the falling edge where it sits in COMPARE
    task automatic apply_stimulus(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] wr);
        int n = 0;
        cpu_req_val = 1'b1; cpu_req_addr = addr; cpu_req_data = data; cpu_req_write = wr;
        while (cpu_req_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("req_accepted", cpu_req_rdy, 1'b1);
        @(negedge clk);
        cpu_req_val = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (mem_req_val !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, mem_req_val, 1'b1);
    endtask

    // Answer a line read; returns on the falling edge of the replayed COMPARE
    task automatic serve_fill(input logic [27:0] ba);
        wait_mem_req("fill_req_seen");
        check_output("fill_rw", mem_req_rw, 1'b0);
        check_output("fill_addr", mem_req_addr, ba);
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_val = 1'b1;
            mem_resp_data = mem_beat(ba + 28'(k));
            @(negedge clk);
        end
        mem_resp_val = 1'b0;
        mem_resp_data = '0;
    endtask

    // Accept a line write and compare each beat against exp_line
    task automatic serve_wb(input logic [27:0] ba, input logic stall);
        wait_mem_req("wb_req_seen");
        check_output("wb_rw", mem_req_rw, 1'b1);
        check_output("wb_addr", mem_req_addr, ba);
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (stall && k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    check_output("wb_stall_valid", mem_req_data_valid, 1'b1);
                    check_output("wb_stall_bits", mem_req_data_bits, exp_line[2]);
                    @(negedge clk);
                end
            end
            check_output("wb_beat_valid", mem_req_data_valid, 1'b1);
            check_output("wb_beat_bits", mem_req_data_bits, exp_line[k]);
            mem_req_data_ready = 1'b1;
            @(negedge clk);
            mem_req_data_ready = 1'b0;
        end
    endtask

    // Build set 1 with dirty 30'h10 in way 0 and clean 30'h90 in way 1, way 0 LRU
    task automatic setup_dirty_set1();
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        serve_fill(28'h4);
        apply_stimulus(30'h10, 32'h12345678, 4'b1111);
        @(negedge clk);
        apply_stimulus(30'h90, 32'h0, 4'b0000);
        serve_fill(28'h24);
        apply_stimulus(30'h90, 32'h0, 4'b0000);
        check_output("touch90_hit", cpu_resp_val, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int done_cnt;
        int extra_mem;

        // Reset state with reset held low
        reset = 1'b0;
        cpu_req_val = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
        flush_req = 1'b0; mem_req_rdy = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_val = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        check_output("rst_cpu_rdy", cpu_req_rdy, 1'b0);
        check_output("rst_resp_val", cpu_resp_val, 1'b0);
        check_output("rst_mem_val", mem_req_val, 1'b0);
        check_output("rst_flush_done", flush_done, 1'b0);
        check_output("rst_data_valid", mem_req_data_valid, 1'b0);
        do_reset();
        check_output("idle_rdy", cpu_req_rdy, 1'b1);

        // Cold load, hit, store merge, back-to-back hits
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        check_output("cold_miss_noresp", cpu_resp_val, 1'b0);
        check_output("cold_miss_rdy", cpu_req_rdy, 1'b0);
        serve_fill(28'h4);
        check_output("cold_resp_val", cpu_resp_val, 1'b1);
        check_output("cold_resp_data", cpu_resp_data, 32'hD000_0400);
        @(negedge clk);
        check_output("resp_pulse_end", cpu_resp_val, 1'b0);
        apply_stimulus(30'h11, 32'h0, 4'b0000);
        check_output("hit11_val", cpu_resp_val, 1'b1);
        check_output("hit11_data", cpu_resp_data, 32'hD000_0401);
        check_output("hit11_nomem", mem_req_val, 1'b0);
        @(negedge clk);
        apply_stimulus(30'h11, 32'hAABBCCDD, 4'b0011);
        check_output("store_noresp", cpu_resp_val, 1'b0);
        check_output("store_hit_rdy", cpu_req_rdy, 1'b1);
        @(negedge clk);
        apply_stimulus(30'h11, 32'h0, 4'b0000);
        check_output("merged_data", cpu_resp_data, 32'hD000_CCDD);
        @(negedge clk);
        cpu_req_val = 1'b1; cpu_req_addr = 30'h10; cpu_req_write = 4'b0000;
        @(negedge clk);
        check_output("b2b_first", cpu_resp_data, 32'hD000_0400);
        check_output("b2b_rdy", cpu_req_rdy, 1'b1);
        cpu_req_addr = 30'h12;
        @(negedge clk);
        cpu_req_val = 1'b0;
        check_output("b2b_second_val", cpu_resp_val, 1'b1);
        check_output("b2b_second", cpu_resp_data, 32'hD000_0402);
        @(negedge clk);

        // Clean eviction follows LRU with no writeback
        do_reset();
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        serve_fill(28'h4);
        apply_stimulus(30'h90, 32'h0, 4'b0000);
        serve_fill(28'h24);
        check_output("fill90_data", cpu_resp_data, 32'hD000_2400);
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        check_output("touch10_data", cpu_resp_data, 32'hD000_0400);
        @(negedge clk);
        apply_stimulus(30'h110, 32'h0, 4'b0000);
        serve_fill(28'h44);
        check_output("fill110_data", cpu_resp_data, 32'hD000_4400);
        @(negedge clk);
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        check_output("keep10_hit", cpu_resp_val, 1'b1);
        check_output("keep10_nomem", mem_req_val, 1'b0);
        @(negedge clk);

        // Dirty eviction with a stalled writeback beat
        do_reset();
        setup_dirty_set1();
        exp_line[0] = {mem_word(28'h4, 3), mem_word(28'h4, 2), mem_word(28'h4, 1), 32'h12345678};
        exp_line[1] = mem_beat(28'h5);
        exp_line[2] = mem_beat(28'h6);
        exp_line[3] = mem_beat(28'h7);
        apply_stimulus(30'h110, 32'h0, 4'b0000);
        serve_wb(28'h4, 1'b1);
        serve_fill(28'h44);
        check_output("evict_fill_data", cpu_resp_data, 32'hD000_4400);
        @(negedge clk);

        // Flush with two dirty lines
        do_reset();
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        serve_fill(28'h4);
        apply_stimulus(30'h10, 32'h11111111, 4'b1111);
        @(negedge clk);
        apply_stimulus(30'h90, 32'h0, 4'b0000);
        serve_fill(28'h24);
        apply_stimulus(30'h90, 32'h22222222, 4'b1111);
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        check_output("flush_blocks_rdy", cpu_req_rdy, 1'b0);
        @(negedge clk);
        flush_req = 1'b0;
        exp_line[0] = {mem_word(28'h4, 3), mem_word(28'h4, 2), mem_word(28'h4, 1), 32'h11111111};
        exp_line[1] = mem_beat(28'h5);
        exp_line[2] = mem_beat(28'h6);
        exp_line[3] = mem_beat(28'h7);
        serve_wb(28'h4, 1'b0);
        exp_line[0] = {mem_word(28'h24, 3), mem_word(28'h24, 2), mem_word(28'h24, 1), 32'h22222222};
        exp_line[1] = mem_beat(28'h25);
        exp_line[2] = mem_beat(28'h26);
        exp_line[3] = mem_beat(28'h27);
        serve_wb(28'h24, 1'b0);
        done_cnt = 0;
        extra_mem = 0;
        for (int c = 0; c < 40; c++) begin
            if (flush_done === 1'b1) done_cnt++;
            if (mem_req_val === 1'b1) extra_mem++;
            @(negedge clk);
        end
        check_output("flush_done_once", 32'(done_cnt), 32'd1);
        check_output("flush_no_extra_wb", 32'(extra_mem), 32'd0);
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        check_output("post_flush10", cpu_resp_data, 32'h11111111);
        check_output("post_flush10_nomem", mem_req_val, 1'b0);
        @(negedge clk);
        apply_stimulus(30'h90, 32'h0, 4'b0000);
        check_output("post_flush90", cpu_resp_data, 32'h22222222);
        @(negedge clk);

        // Reset in the middle of a writeback
        do_reset();
        setup_dirty_set1();
        apply_stimulus(30'h110, 32'h0, 4'b0000);
        wait_mem_req("abort_wb_req");
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_req_data_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_data_ready = 1'b0;
        check_output("abort_beat2_valid", mem_req_data_valid, 1'b1);
        reset = 1'b0;
        #1;
        check_output("abort_data_valid", mem_req_data_valid, 1'b0);
        check_output("abort_mem_val", mem_req_val, 1'b0);
        check_output("abort_cpu_rdy", cpu_req_rdy, 1'b0);
        check_output("abort_data_bits", mem_req_data_bits, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        apply_stimulus(30'h10, 32'h0, 4'b0000);
        check_output("after_abort_miss", cpu_resp_val, 1'b0);
        serve_fill(28'h4);
        check_output("after_abort_data", cpu_resp_data, 32'hD000_0400);
        @(negedge clk);

        n = vectors;
        $display("== %0d vectors applied, %0d miscompares ==", n, miscompares);
        $finish;
    end
endmodule
